debounce_cmd_bank: RTL and testbench
====================================

// Module: debounce_cmd_bank
// PURPOSE
//  N-channel push-button conditioner with parametrised channel count, filter depth and polarity.
//  Each raw input passes through a 2-FF synchroniser and a stability counter.
//  Each channel yields a level, a press pulse and a release pulse.
//  The release pulses are merged into a single registered command strobe with an index,
//  fixed-priority arbitration and a post-command lockout.
//  Sits between board buttons and the mode controller (PC->RAM, RAM->PC, PROCESS, IDLE).
// PARAMETERS
//  N_CH        4        number of button channels (1..16)
//  CNT_MAX     250000   consecutive stable synchronised cycles required to accept a change (>=2)
//  ACTIVE_LOW  1        1: raw input low = pressed; 0: raw input high = pressed
//  LOCKOUT     1024     cycles after a command during which further releases are ignored (0 = none)
// PORTS
//  clk        in   1            system clock; all logic on rising edge
//  rst        in   1            synchronous reset, active-high
//  pb_raw     in   N_CH         asynchronous raw button inputs
//  db_state   out  N_CH         debounced level, 1 = pressed
//  db_down    out  N_CH         1-cycle pulse, pressed accepted
//  db_up      out  N_CH         1-cycle pulse, release accepted
//  cmd_valid  out  1            1-cycle command strobe
//  cmd_idx    out  IDX_W        channel index of command; held until next cmd_valid
//  cmd_drop   out  1            1-cycle pulse: a release was lost (lower priority or in lockout)
// BEHAVIOUR
//  Widths
//   - IDX_W = max(1, $clog2(N_CH)); CNT_W = $clog2(CNT_MAX); LK_W = $clog2(LOCKOUT+1).
//  Reset
//   - rst=1 at an edge clears sync FFs to the "released" value.
//   - Clears all counters, db_state, db_down, db_up, cmd_valid, cmd_idx and cmd_drop to 0.
//   - Clears the lockout counter to 0. Reset mid-press discards partial count.
//  Synchroniser
//   - s0 <= pb_raw ^ {N_CH{ACTIVE_LOW}}; s1 <= s0.
//   - Logical "pressed" = s1 (after polarity fix).
//  Filter (per channel)
//   - s1 == db_state: cnt <= 0.
//   - s1 != db_state and cnt != CNT_MAX-1: cnt <= cnt+1.
//   - s1 != db_state and cnt == CNT_MAX-1: db_state <= ~db_state, cnt <= 0.
//   - Toggle to 1: db_down=1 in the same cycle db_state becomes 1.
//   - Toggle to 0: db_up=1 in the same cycle db_state becomes 0.
//   - A glitch shorter than CNT_MAX cycles (at s1) is fully rejected; the counter restarts from 0.
//   - Latency raw edge -> db_state change = 2 + CNT_MAX cycles.
//   - The counter never wraps: saturation is impossible because it clears on accept.
//  Command arbiter (registered)
//   - Input is db_up. Cycle after any db_up bit is set with lockout counter == 0:
//     - cmd_valid=1 and cmd_idx = lowest set index.
//     - cmd_drop=1 if more than one bit was set.
//     - lockout counter loads LOCKOUT.
//   - Lockout counter != 0: decrement each cycle. Any db_up in this window gives cmd_drop=1 next cycle, no cmd_valid.
//   - Lockout reaching 0 and a db_up in the same cycle: the db_up is accepted (counter is checked before decrement).
//   - db_down never generates commands. cmd_idx only changes when cmd_valid=1.
// STRUCTURE
//  - Shared package/header:
//    - clog2 helper.
//    - localparams for channel map: CH_PC_RAM=0, CH_RAM_PC=1, CH_PROCESS=2, CH_IDLE=3.
//  - Sub-module debounce_channel (params CNT_MAX, ACTIVE_LOW): sync + filter + edge pulses, one per channel via generate.
//  - Arbiter and lockout live in the top module.
// TESTING (sim with CNT_MAX=4, LOCKOUT=8, N_CH=4, ACTIVE_LOW=1)
//  1. Reset: rst=1 for 2 cycles with pb_raw=4'hF -> all outputs 0; stay 0 for 20 cycles after release.
//  2. Debounce accept: pb_raw[0] low at cycle T, held -> db_state[0]=1 and db_down[0]=1 at T+6, single cycle.
//     - Raise pb_raw[0] later -> db_up[0] six cycles later.
//     - cmd_valid=1 and cmd_idx=0 on the next cycle.
//  3. Glitch reject: pb_raw[1] low for 3 cycles, then high -> db_state[1] stays 0, no pulses.
//     - Bounce pattern of 1/2/3-cycle pulses, then stable low -> exactly one db_down[1].
//  4. Simultaneous release: channels 1 and 3 released in the same cycle -> cmd_valid with cmd_idx=1 and cmd_drop=1 in the same cycle.
//  5. Lockout: release ch2 three cycles after a ch0 command -> cmd_drop=1, no cmd_valid, cmd_idx stays 0.
//     - Release ch2 after lockout expiry -> cmd_valid, cmd_idx=2.
//  6. Reset mid-count: assert rst while cnt=2 on ch0 with input still pressed -> after reset, db_down[0] occurs 6 cycles after rst release, not earlier.

Source files
------------

// File: rtl/debounce_cmd_bank_pkg.sv
// Shared helpers and the board channel map for the push-button command bank.
package debounce_cmd_bank_pkg;
  localparam int CH_PC_RAM  = 0;
  localparam int CH_RAM_PC  = 1;
  localparam int CH_PROCESS = 2;
  localparam int CH_IDLE    = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/debounce_cmd_bank_channel.sv
// One button: 2-FF synchroniser, stability filter, and press/release pulses.
module debounce_channel
  import debounce_cmd_bank_pkg::*;
#(
  parameter int CNT_MAX    = 250000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic db_state,
  output logic db_down,
  output logic db_up
);
  localparam int CNT_W = clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             r_s0, r_s1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state, r_down, r_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_down  <= 1'b0;
      r_up    <= 1'b0;
    end else begin
      r_s0   <= pb_raw ^ ACTIVE_LOW;
      r_s1   <= r_s0;
      r_down <= 1'b0;
      r_up   <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (r_s1 == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt   <= '0;
        r_state <= ~r_state;
        r_down  <= ~r_state;
        r_up    <= r_state;
      end
    end
  end

  assign db_state = r_state;
  assign db_down  = r_down;
  assign db_up    = r_up;
endmodule

// File: rtl/debounce_cmd_bank.sv
// N-channel button conditioner; release pulses become one arbitrated command strobe with lockout.
module debounce_cmd_bank
  import debounce_cmd_bank_pkg::*;
#(
  parameter int  N_CH       = 4,
  parameter int  CNT_MAX    = 250000,
  parameter bit  ACTIVE_LOW = 1'b1,
  parameter int  LOCKOUT    = 1024,
  localparam int IDX_W      = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   pb_raw,
  output logic [N_CH-1:0]   db_state,
  output logic [N_CH-1:0]   db_down,
  output logic [N_CH-1:0]   db_up,
  output logic              cmd_valid,
  output logic [IDX_W-1:0]  cmd_idx,
  output logic              cmd_drop
);
  localparam int LK_W = (clog2(LOCKOUT + 1) > 1) ? clog2(LOCKOUT + 1) : 1;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .CNT_MAX    (CNT_MAX),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .pb_raw   (pb_raw[g]),
      .db_state (db_state[g]),
      .db_down  (db_down[g]),
      .db_up    (db_up[g])
    );
  end

  logic             w_any, w_multi;
  logic [IDX_W-1:0] w_idx;
  logic             r_cmd_valid, r_cmd_drop;
  logic [IDX_W-1:0] r_cmd_idx;
  logic [LK_W-1:0]  r_lk;

  always_comb begin
    w_any   = |db_up;
    w_multi = (db_up & (db_up - N_CH'(1))) != '0;
    w_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (db_up[i]) w_idx = IDX_W'(i);
  end

  // Lockout is tested before it decrements, so a release landing on the zero cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_idx   <= '0;
      r_cmd_drop  <= 1'b0;
      r_lk        <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_drop  <= 1'b0;
      if (r_lk == '0) begin
        if (w_any) begin
          r_cmd_valid <= 1'b1;
          r_cmd_idx   <= w_idx;
          r_cmd_drop  <= w_multi;
          r_lk        <= LK_W'(LOCKOUT);
        end
      end else begin
        r_lk       <= r_lk - 1'b1;
        r_cmd_drop <= w_any;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_idx   = r_cmd_idx;
  assign cmd_drop  = r_cmd_drop;
endmodule

// File: tb/tb_debounce_cmd_bank.sv
// Directed bench: N_CH=4, CNT_MAX=4, ACTIVE_LOW=1, LOCKOUT=8.
module tb_debounce_cmd_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb_raw;
  logic [3:0] db_state, db_down, db_up;
  logic       cmd_valid, cmd_drop;
  logic [1:0] cmd_idx;

  int n_chk = 0, n_fail = 0;
  int n_down = 0, n_up = 0, n_cmd = 0;
  int d0, u0;
  logic any_nz;

  debounce_cmd_bank #(
    .N_CH(4), .CNT_MAX(4), .ACTIVE_LOW(1'b1), .LOCKOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .pb_raw(pb_raw),
    .db_state(db_state), .db_down(db_down), .db_up(db_up),
    .cmd_valid(cmd_valid), .cmd_idx(cmd_idx), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n edges; outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_down += $countones(db_down);
      n_up   += $countones(db_up);
      n_cmd  += int'(cmd_valid);
    end
  endtask

  initial begin
    rst    = 1'b1;
    pb_raw = 4'hF;
    step(2);
    chk("rst_outs", {db_state, db_down, db_up, cmd_valid, cmd_idx, cmd_drop}, 0);
    rst    = 1'b0;
    any_nz = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if ({db_state, db_down, db_up, cmd_valid, cmd_idx, cmd_drop} != 0) any_nz = 1'b1;
    end
    chk("idle_quiet", any_nz, 0);

    // Accept a press/release on ch0 and its command.
    pb_raw[0] = 1'b0;
    step(5);  chk("acc_early",  db_state, 4'b0000);
    step(1);  chk("acc_state",  db_state, 4'b0001);
              chk("acc_down",   db_down,  4'b0001);
    step(1);  chk("down_single", db_down, 4'b0000);
    pb_raw[0] = 1'b1;
    step(5);  chk("rel_early",  db_up,    4'b0000);
    step(1);  chk("rel_up",     db_up,    4'b0001);
              chk("rel_state",  db_state, 4'b0000);
    step(1);  chk("cmd0_valid", cmd_valid, 1);
              chk("cmd0_idx",   cmd_idx,   0);
              chk("cmd0_drop",  cmd_drop,  0);
    step(1);  chk("cmd0_pulse", cmd_valid, 0);
    step(10);

    // Glitch rejection, then bounce settling to one press.
    d0 = n_down; u0 = n_up;
    pb_raw[1] = 1'b0; step(3); pb_raw[1] = 1'b1; step(10);
    chk("glitch_state", db_state, 4'b0000);
    chk("glitch_pulses", (n_down - d0) + (n_up - u0), 0);
    d0 = n_down;
    pb_raw[1] = 1'b0; step(1); pb_raw[1] = 1'b1; step(1);
    pb_raw[1] = 1'b0; step(2); pb_raw[1] = 1'b1; step(1);
    pb_raw[1] = 1'b0; step(3); pb_raw[1] = 1'b1; step(1);
    pb_raw[1] = 1'b0; step(12);
    chk("bounce_state", db_state, 4'b0010);
    chk("bounce_downs", n_down - d0, 1);

    // Simultaneous release of ch1 and ch3.
    pb_raw[3] = 1'b0; step(8);
    chk("sim_press", db_state, 4'b1010);
    pb_raw[1] = 1'b1; pb_raw[3] = 1'b1;
    step(5);  chk("sim_up_early", db_up, 4'b0000);
    step(1);  chk("sim_up",    db_up,     4'b1010);
    step(1);  chk("sim_valid", cmd_valid, 1);
              chk("sim_idx",   cmd_idx,   1);
              chk("sim_drop",  cmd_drop,  1);
    step(10);

    // Release of ch2 inside the lockout after a ch0 command is dropped.
    pb_raw[0] = 1'b0; pb_raw[2] = 1'b0; step(8);
    chk("lk_press", db_state, 4'b0101);
    pb_raw[0] = 1'b1; step(4);
    pb_raw[2] = 1'b1; step(3);
    chk("lk_cmd_valid", cmd_valid, 1);
    chk("lk_cmd_idx",   cmd_idx,   0);
    step(3);  chk("lk_up2",    db_up,     4'b0100);
    step(1);  chk("lk_drop",   cmd_drop,  1);
              chk("lk_novalid", cmd_valid, 0);
              chk("lk_idx_held", cmd_idx,  0);

    // After expiry ch2 commands; ch1 release exactly on the zero cycle is accepted.
    pb_raw[1] = 1'b0; pb_raw[2] = 1'b0; step(8);
    chk("exp_press", db_state, 4'b0110);
    pb_raw[2] = 1'b1;
    step(6);  chk("exp_up2",   db_up,     4'b0100);
    step(1);  chk("exp_valid", cmd_valid, 1);
              chk("exp_idx",   cmd_idx,   2);
              chk("exp_drop",  cmd_drop,  0);
    step(2);  pb_raw[1] = 1'b1;
    step(6);  chk("edge_up1",  db_up,     4'b0010);
    step(1);  chk("edge_valid", cmd_valid, 1);
              chk("edge_idx",  cmd_idx,   1);
              chk("edge_drop", cmd_drop,  0);
    step(10);

    // Reset while ch0 is mid-count discards the partial count.
    pb_raw[0] = 1'b0; step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("mid_rst_idx",   cmd_idx,  0);
    chk("mid_rst_state", db_state, 4'b0000);
    d0 = n_down;
    step(5);  chk("mid_early", db_state, 4'b0000);
              chk("mid_nodown", n_down - d0, 0);
    step(1);  chk("mid_down",  db_down,  4'b0001);
              chk("mid_state", db_state, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
